// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with a memready handshake.
// Optional bne support is enabled with the macro MULTICYCLE_CONTROL_BNE_EN.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       memready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       irwrite,
    output logic       alusrca,
    output logic       regwrite,
    output logic       regdst,
    output logic [1:0] pcsource,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       illegal
`ifdef MULTICYCLE_CONTROL_BNE_EN
    ,
    output logic       branchne
`endif
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ORIEX  = 4'd11,
        IWB    = 4'd12,
`ifdef MULTICYCLE_CONTROL_BNE_EN
        BNE    = 4'd13,
`endif
        TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
`ifdef MULTICYCLE_CONTROL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    state_t state_r;
    state_t next_state_s;
    logic   illegal_r;

    // State register and sticky illegal flag; the flag rises on the edge that enters TRAP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            illegal_r <= illegal_r | (next_state_s == TRAP);
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEMADR
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FETCH: begin
                if (memready) begin
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      next_state_s = EXEC;
                    OP_LW, OP_SW:  next_state_s = MEMADR;
                    OP_BEQ:        next_state_s = BRANCH;
                    OP_J:          next_state_s = JUMP;
                    OP_ADDI:       next_state_s = ADDIEX;
                    OP_ORI:        next_state_s = ORIEX;
`ifdef MULTICYCLE_CONTROL_BNE_EN
                    OP_BNE:        next_state_s = BNE;
`endif
                    default:       next_state_s = TRAP;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW) begin
                    next_state_s = MEMRD;
                end else begin
                    next_state_s = MEMWR;
                end
            end
            MEMRD: begin
                if (memready) begin
                    next_state_s = MEMWB;
                end else begin
                    next_state_s = MEMRD;
                end
            end
            MEMWR: begin
                if (memready) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEMWR;
                end
            end
            MEMWB:  next_state_s = FETCH;
            EXEC:   next_state_s = ALUWB;
            ALUWB:  next_state_s = FETCH;
            BRANCH: next_state_s = FETCH;
            JUMP:   next_state_s = FETCH;
            ADDIEX: next_state_s = IWB;
            ORIEX:  next_state_s = IWB;
            IWB:    next_state_s = FETCH;
`ifdef MULTICYCLE_CONTROL_BNE_EN
            BNE:    next_state_s = FETCH;
`endif
            TRAP:   next_state_s = TRAP;
            // Unused encodings are treated as a fault and parked in TRAP
            default: next_state_s = TRAP;
        endcase
    end

    // Moore output decode; only FETCH's irwrite/pcwrite look at memready
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        alusrca     = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        pcsource    = 2'b00;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
`ifdef MULTICYCLE_CONTROL_BNE_EN
        branchne    = 1'b0;
`endif
        case (state_r)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
            end
            DECODE: begin
                alusrcb = 2'b11;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
            end
            IWB: begin
                regwrite = 1'b1;
            end
`ifdef MULTICYCLE_CONTROL_BNE_EN
            BNE: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                branchne    = 1'b1;
            end
`endif
            default: begin
                pcwrite = 1'b0;
            end
        endcase
    end

    assign state   = state_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level reference model feeds an
// expected-response queue, a separate monitor checks every cycle.
module tb_multicycle_control;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ORIEX  = 4'd11;
    localparam logic [3:0] S_IWB    = 4'd12;
    localparam logic [3:0] S_BNE    = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       memready;
    logic [5:0] opcode;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic       irwrite, alusrca, regwrite, regdst, illegal, branchne;
    logic [1:0] pcsource, alusrcb, aluop;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memready(memready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .irwrite(irwrite), .alusrca(alusrca), .regwrite(regwrite),
        .regdst(regdst), .pcsource(pcsource), .alusrcb(alusrcb),
        .aluop(aluop), .state(state), .illegal(illegal)
`ifdef MULTICYCLE_CONTROL_BNE_EN
        , .branchne(branchne)
`endif
    );
`ifndef MULTICYCLE_CONTROL_BNE_EN
    assign branchne = 1'b0;
`endif

    logic [17:0] dut_ctl;
    assign dut_ctl = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                      alusrca, regwrite, regdst, pcsource, alusrcb, aluop, illegal, branchne};

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cyc     = 32'd0;
    logic        ill_m   = 1'b0;

    // Control outputs each state is required to show
    function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic mr, input logic ill);
        logic pcw, pcwc, io, mrd, mwr, m2r, irw, asa, rw, rd, bne;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, io, mrd, mwr, m2r, irw, asa, rw, rd, bne} = 11'd0;
        {pcs, asb, aop} = 6'd0;
        case (st)
            S_FETCH:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            S_DECODE: asb = 2'b11;
            S_MEMADR: begin asa = 1'b1; asb = 2'b10; end
            S_MEMRD:  begin mrd = 1'b1; io = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
            S_MEMWR:  begin mwr = 1'b1; io = 1'b1; end
            S_EXEC:   begin asa = 1'b1; aop = 2'b10; end
            S_ALUWB:  begin rd = 1'b1; rw = 1'b1; end
            S_BRANCH: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            S_JUMP:   begin pcw = 1'b1; pcs = 2'b10; end
            S_ADDIEX: begin asa = 1'b1; asb = 2'b10; end
            S_ORIEX:  begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
            S_IWB:    rw = 1'b1;
            S_BNE:    begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; bne = 1'b1; end
            default:  pcw = 1'b0;
        endcase
        return {pcw, pcwc, io, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop, ill, bne};
    endfunction

    function automatic logic rb();
        logic [31:0] t;
        t = $urandom;
        return t[0];
    endfunction

    function automatic logic [5:0] rop();
        logic [31:0] t;
        t = $urandom;
        return t[5:0];
    endfunction

    // One clock: apply inputs at the falling edge and queue what this cycle must show
    task automatic cycle(input logic rn, input logic mr, input logic [5:0] op, input logic [3:0] st);
        exp_t e;
        @(negedge clk);
        rst_n    = rn;
        memready = mr;
        opcode   = op;
        e.st  = st;
        e.ctl = exp_ctl(st, mr, ill_m);
        e.cyc = cyc;
        q.push_back(e);
        cyc = cyc + 32'd1;
        if (!rn) ill_m = 1'b0;
    endtask

    // Instruction-level model: fw/mw are memory stall counts, rmode 1/2 resets in a fetch/mem stall
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int rmode);
        logic [3:0] mst;
        int         tn;
        for (int i = 0; i < fw; i++) begin
            if (rmode == 1 && i == fw - 1) begin
                cycle(1'b0, 1'b0, rop(), S_FETCH);
                return;
            end
            cycle(1'b1, 1'b0, rop(), S_FETCH);
        end
        cycle(1'b1, 1'b1, rop(), S_FETCH);
        cycle(1'b1, rb(), op, S_DECODE);
        case (op)
            6'h00: begin cycle(1'b1, rb(), rop(), S_EXEC);   cycle(1'b1, rb(), rop(), S_ALUWB); end
            6'h04: cycle(1'b1, rb(), rop(), S_BRANCH);
            6'h02: cycle(1'b1, rb(), rop(), S_JUMP);
            6'h08: begin cycle(1'b1, rb(), rop(), S_ADDIEX); cycle(1'b1, rb(), rop(), S_IWB); end
            6'h0D: begin cycle(1'b1, rb(), rop(), S_ORIEX);  cycle(1'b1, rb(), rop(), S_IWB); end
            6'h23, 6'h2B: begin
                cycle(1'b1, rb(), op, S_MEMADR);
                mst = (op == 6'h23) ? S_MEMRD : S_MEMWR;
                for (int i = 0; i < mw; i++) begin
                    if (rmode == 2 && i == mw - 1) begin
                        cycle(1'b0, 1'b0, rop(), mst);
                        return;
                    end
                    cycle(1'b1, 1'b0, rop(), mst);
                end
                cycle(1'b1, 1'b1, rop(), mst);
                if (op == 6'h23) cycle(1'b1, rb(), rop(), S_MEMWB);
            end
`ifdef MULTICYCLE_CONTROL_BNE_EN
            6'h05: cycle(1'b1, rb(), rop(), S_BNE);
`endif
            default: begin
                ill_m = 1'b1;
                tn = 10 + $urandom_range(0, 3);
                for (int i = 0; i < tn; i++) cycle(1'b1, rb(), rop(), S_TRAP);
                cycle(1'b0, rb(), rop(), S_TRAP);
            end
        endcase
    endtask

    // Monitor: checks every queued cycle well after the falling-edge input update
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL state cyc=%0d got=%0d exp=%0d", e.cyc, state, e.st);
                end
                n_tests++;
                if (dut_ctl !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl cyc=%0d st=%0d got=%b exp=%b", e.cyc, e.st, dut_ctl, e.ctl);
                end
            end
        end
    end

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        int         r;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D, 6'h05};
        rst_n    = 1'b0;
        memready = 1'b0;
        opcode   = 6'h00;
        repeat (2) @(negedge clk);
        cycle(1'b0, 1'b1, rop(), S_FETCH);
        cycle(1'b0, 1'b0, rop(), S_FETCH);

        run_instr(6'h23, 0, 0, 0);
        run_instr(6'h2B, 0, 3, 0);
        run_instr(6'h00, 0, 0, 0);
        run_instr(6'h0D, 1, 0, 0);
        run_instr(6'h3F, 0, 0, 0);
        run_instr(6'h23, 0, 2, 2);
        run_instr(6'h2B, 2, 2, 1);
        run_instr(6'h05, 0, 0, 0);
        run_instr(6'h08, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            op = (r == 0) ? rop() : ops[$urandom_range(0, 7)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
        end

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: reset that is synchronous and active-low.
REQ-003 SHALL have port opcode, input, 6 bits: instruction[31:26] from the instruction register.
REQ-004 SHALL have port memready, input, 1 bit: memory handshake; the current access completes in a cycle where it is 1.
REQ-005 SHALL have the following 1-bit outputs: pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst.
REQ-006 SHALL have the following 2-bit outputs: pcsource, alusrcb, aluop (aluop: 00 add, 01 sub, 10 use funct field, 11 or).
REQ-007 SHALL have port state, output, 4 bits: current state code.
REQ-008 SHALL have port illegal, output, 1 bit: sticky undefined-opcode flag.

Function
REQ-009 SHALL be a Moore FSM; all outputs SHALL be pure functions of the registered state, except irwrite and pcwrite in FETCH, which are also gated by memready.
REQ-010 SHALL use these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ORIEX=11, IWB=12, TRAP=15.
REQ-011 SHALL drive every output not listed for a state to 0.
REQ-012 FETCH SHALL drive memread=1, alusrcb=01, aluop=00, pcsource=00, and irwrite=pcwrite=memready; FETCH SHALL stay while memready=0 and go to DECODE otherwise.
REQ-013 DECODE SHALL drive alusrcb=11 and aluop=00, then dispatch on opcode: 0x00 to EXEC; 0x23 or 0x2B to MEMADR; 0x04 to BRANCH; 0x02 to JUMP; 0x08 to ADDIEX; 0x0D to ORIEX; any other opcode to TRAP.
REQ-014 MEMADR SHALL drive alusrca=1, alusrcb=10, aluop=00, then go to MEMRD if opcode=0x23 and to MEMWR otherwise.
REQ-015 MEMRD SHALL drive memread=1 and iord=1, stay while memready=0, and go to MEMWB otherwise.
REQ-016 MEMWB SHALL drive regwrite=1 and memtoreg=1 (regdst=0), then go to FETCH.
REQ-017 MEMWR SHALL drive memwrite=1 and iord=1, stay while memready=0, and go to FETCH otherwise.
REQ-018 EXEC SHALL drive alusrca=1, alusrcb=00, aluop=10, then go to ALUWB.
REQ-019 ALUWB SHALL drive regdst=1 and regwrite=1, then go to FETCH.
REQ-020 BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, then go to FETCH.
REQ-021 JUMP SHALL drive pcwrite=1 and pcsource=10, then go to FETCH.
REQ-022 ADDIEX SHALL drive alusrca=1, alusrcb=10, aluop=00, then go to IWB.
REQ-023 ORIEX SHALL drive alusrca=1, alusrcb=10, aluop=11, then go to IWB.
REQ-024 IWB SHALL drive regwrite=1 (regdst=0, memtoreg=0), then go to FETCH.
REQ-025 TRAP SHALL drive all control outputs to 0, hold illegal=1, and remain in TRAP until reset.
REQ-026 SHALL sample opcode only in DECODE and MEMADR; opcode changes in other states SHALL have no effect.
REQ-027 memread and memwrite SHALL never both be 1 in the same cycle.

Reset
REQ-028 When rst_n=0 at a rising edge of clk, the block SHALL enter FETCH and clear illegal, from any state, including mid-wait in MEMRD, MEMWR or FETCH.
REQ-029 While in reset-held FETCH, outputs SHALL follow REQ-012 (memread=1), so no write strobe is ever asserted during reset.

Configuration
REQ-030 With macro MULTICYCLE_CONTROL_BNE_EN defined, DECODE SHALL send opcode 0x05 to state BNE=13, which drives the BRANCH outputs plus output branchne=1, then goes to FETCH.
REQ-031 With MULTICYCLE_CONTROL_BNE_EN defined, branchne SHALL be 0 in all other states.
REQ-032 Without MULTICYCLE_CONTROL_BNE_EN, opcode 0x05 SHALL go to TRAP and port branchne SHALL not exist.

Verification
REQ-033 Reset, then lw (0x23) with memready=1 throughout -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 in state 4; 5 cycles per instruction.
REQ-034 sw (0x2B) with memready held 0 for 3 cycles in MEMWR -> state stays 5 for 4 cycles with memwrite=1 and iord=1, then returns to 0.
REQ-035 R-type (0x00) -> aluop=10 in state 6, regdst=1 in state 7; ori (0x0D) -> aluop=11 in state 11, then 12.
REQ-036 Opcode 0x3F -> TRAP with illegal=1, held for 10 cycles regardless of memready; rst_n=0 for one edge -> state 0 and illegal=0.
REQ-037 rst_n asserted while in MEMRD with memready=0 -> next state 0, memwrite never 1.
REQ-038 With MULTICYCLE_CONTROL_BNE_EN defined, opcode 0x05 -> state 13 with branchne=1, pcwritecond=1, aluop=01; without it -> state 15.
